// File: rtl/lfsr_randomizer.sv
// lfsr_randomizer: seedable Fibonacci LFSR that produces one pseudo-random word per clock.
// While start is high the state tracks the seed input. While start is low the
// register shifts left once per clock, and the feedback bit enters at bit 0.
// A zero seed is replaced by 1, because the all-zero state would never leave itself.
// Consumers read out[7:0] as an unsigned fraction, out[7:0] / 256.
module lfsr_randomizer #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] TAPS        = 16'hB400,
  parameter logic [WIDTH-1:0] RESET_VALUE = 16'h0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             valid
);

  // Smallest nonzero state. It is the substitute wherever the state would otherwise be zero.
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] state_next;
  logic             valid_reg;
  logic             valid_next;
  logic [WIDTH-1:0] tap_terms;
  logic             fb;

  // Mask each state bit with its tap, then XOR-reduce the terms into the feedback bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_tap
      assign tap_terms[gi] = state_reg[gi] & TAPS[gi];
    end
  endgenerate

  assign fb = ^tap_terms;

  // Next-state selection: load the guarded seed, or advance the shift register.
  always_comb begin
    state_next = state_reg;
    valid_next = valid_reg;
    if (start) begin
      state_next = (seed == '0) ? ONE : seed;
      valid_next = 1'b0;
    end else begin
      // The zero state cannot be reached from a nonzero state. This guard only
      // recovers from an externally corrupted register.
      state_next = (state_reg == '0) ? ONE : {state_reg[WIDTH-2:0], fb};
      valid_next = 1'b1;
    end
  end

  // State and valid registers. Reset acts at once and overrides start and seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RESET_VALUE;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
    end
  end

  assign out   = state_reg;
  assign valid = valid_reg;

endmodule

// File: tb/tb_lfsr_randomizer.sv
// tb_lfsr_randomizer: directed scoreboard bench for the 16-bit LFSR randomizer.
module tb_lfsr_randomizer;

  logic        clk;
  logic        rst;
  logic [15:0] seed;
  logic        start;
  logic [15:0] out;
  logic        valid;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] word;
    logic        vld;
  } exp_t;

  exp_t sb_q[$];

  // Reference state kept by the bench
  logic [15:0] m_state;
  logic        m_valid;

  lfsr_randomizer #(
    .WIDTH(16),
    .TAPS(16'hB400),
    .RESET_VALUE(16'h0001)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seed(seed),
    .start(start),
    .out(out),
    .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Polynomial x^16+x^14+x^13+x^11+1, written out bit by bit.
  function automatic logic [15:0] ref_next(input logic [15:0] s, input logic st,
                                           input logic [15:0] sd);
    logic f;
    if (st) return (sd == 16'h0000) ? 16'h0001 : sd;
    if (s == 16'h0000) return 16'h0001;
    f = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], f};
  endfunction

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Drive one clock's inputs and push the expected result.
  // Then take the edge and compare the DUT output against the popped entry.
  task automatic step(input string tag, input logic st, input logic [15:0] sd, input bit quiet);
    exp_t e;
    start = st;
    seed  = sd;
    m_state = ref_next(m_state, st, sd);
    m_valid = st ? 1'b0 : 1'b1;
    sb_q.push_back('{word: m_state, vld: m_valid});
    @(posedge clk);
    #1;
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check16({tag, "_out"}, out, e.word);
      check16({tag, "_valid"}, {15'd0, valid}, {15'd0, e.vld});
      if (!quiet)
        $display("[%0t] %s start=%b seed=%h -> out=%h valid=%b (exp %h/%b)",
                 $time, tag, st, sd, out, valid, e.word, e.vld);
    end
  endtask

  initial begin
    int  first_ret;
    bit  saw_zero;
    real frac;

    rst   = 1'b0;
    start = 1'b0;
    seed  = 16'h0000;
    m_state = 16'h0001;
    m_valid = 1'b0;

    // Asynchronous reset: check well before the first clock edge.
    #1 rst = 1'b1;
    #1;
    check16("reset_async_out", out, 16'h0001);
    check16("reset_async_valid", {15'd0, valid}, 16'd0);
    $display("[%0t] reset asserted -> out=%h valid=%b", $time, out, valid);
    @(posedge clk);
    @(posedge clk);
    #1;
    check16("reset_hold_out", out, 16'h0001);
    rst = 1'b0;
    m_state = 16'h0001;
    m_valid = 1'b0;

    // First edge after release advances from RESET_VALUE.
    step("post_reset_run", 1'b0, 16'h0000, 1'b0);

    // Load the seed, then run.
    step("load_4242", 1'b1, 16'h4242, 1'b0);
    check16("frac_low_byte", {8'd0, out[7:0]}, 16'h0042);
    frac = real'(out[7:0]) / 256.0;
    checks++;
    assert (frac == 0.2578125) else begin
      errors++;
      $error("FAIL frac_value: observed %f expected %f", frac, 0.2578125);
    end
    step("run1", 1'b0, 16'h4242, 1'b0);
    check16("run1_const", out, 16'h8484);
    step("run2", 1'b0, 16'h4242, 1'b0);
    check16("run2_const", out, 16'h0908);
    step("run3", 1'b0, 16'h4242, 1'b0);
    check16("run3_const", out, 16'h1210);

    // A held start tracks seed changes.
    step("hold_a", 1'b1, 16'h1234, 1'b0);
    step("hold_b", 1'b1, 16'hA5A5, 1'b0);

    // Zero-seed guard.
    step("zero_seed", 1'b1, 16'h0000, 1'b0);
    check16("zero_seed_const", out, 16'h0001);
    step("zero_run", 1'b0, 16'h0000, 1'b0);
    check16("zero_run_const", out, 16'h0002);

    // Period: load 0x4242, then run 65535 edges.
    step("period_load", 1'b1, 16'h4242, 1'b0);
    first_ret = 0;
    saw_zero  = 1'b0;
    for (int i = 1; i <= 65535; i++) begin
      step("period", 1'b0, 16'h4242, 1'b1);
      if (out == 16'h0000) saw_zero = 1'b1;
      if (out == 16'h4242 && first_ret == 0) first_ret = i;
    end
    $display("[%0t] period run done: out=%h first_return=%0d saw_zero=%0d",
             $time, out, first_ret, saw_zero);
    check16("period_end_out", out, 16'h4242);
    check16("period_first_return", 16'(first_ret), 16'hFFFF);
    check16("period_never_zero", {15'd0, saw_zero}, 16'd0);

    // Mid-run reload.
    step("midrun_a", 1'b0, 16'h4242, 1'b0);
    step("midrun_b", 1'b0, 16'h4242, 1'b0);
    step("reload_beef", 1'b1, 16'hBEEF, 1'b0);
    check16("reload_beef_const", out, 16'hBEEF);
    step("beef_run", 1'b0, 16'hBEEF, 1'b0);

    // Mid-run asynchronous reset between edges.
    step("pre_rst_run", 1'b0, 16'hBEEF, 1'b0);
    rst = 1'b1;
    #2;
    check16("midrun_rst_out", out, 16'h0001);
    check16("midrun_rst_valid", {15'd0, valid}, 16'd0);
    $display("[%0t] mid-run reset -> out=%h valid=%b", $time, out, valid);
    @(posedge clk);
    #1;
    check16("rst_dominates_out", out, 16'h0001);
    rst = 1'b0;
    m_state = 16'h0001;
    m_valid = 1'b0;
    step("after_rst_run", 1'b0, 16'h0000, 1'b0);
    check16("after_rst_const", out, 16'h0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_randomizer.md
Name: lfsr_randomizer

Overview:
- Seedable 16-bit Fibonacci LFSR pseudo-random number generator.
- Sits beside consumers that need one fresh random word per clock, such as exploration or action selection.
- Consumers take the low byte out[7:0] as an unsigned fraction, out[7:0] × 2^-8, giving values in [0, 255/256].
- Single clock domain; no handshake beyond the start/run control.

Parameters:
- WIDTH, 16, state/seed/output width. The block is specified and verified at 16 only.
- TAPS, 16'hB400, feedback mask (bits 15,13,12,10 = x^16+x^14+x^13+x^11+1, maximal length).
- RESET_VALUE, 16'h0001, state loaded by reset. Must be nonzero.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- seed  input  16  seed value, sampled while start is high.
- start  input  1  active-low run control: 1 = load/hold seed, 0 = run (advance each clock).
- out  output  16  current LFSR state / random word (registered).
- valid  output  1  high once out holds a generated, not seeded, value.

Behaviour:
- Reset: rst=1 asynchronously forces out=RESET_VALUE and valid=0. Reset dominates start and seed, including mid-run. After release the block acts on the next rising edge.
- All other updates occur on the rising clk edge, with start and seed sampled at that edge.
- Load (start=1):
  - out <= seed, or out <= 16'h0001 when seed==0 (zero-lock guard).
  - valid <= 0.
  - Repeated while start is held high, so seed changes are tracked with 1-cycle latency.
- Run (start=0):
  - fb = XOR-reduce(out & TAPS) = out[15]^out[13]^out[12]^out[10].
  - out <= {out[14:0], fb}.
  - valid <= 1.
  - One new word per clock; first generated value appears 1 cycle after start first samples low.
- Zero-state guard in run: if out==0 (unreachable by construction), next out = 16'h0001.
- Sequence properties:
  - Period 65535.
  - out never equals 0 after a load or reset.
  - The sequence returns to the loaded seed after exactly 65535 run cycles.
- Start toggling:
  - start 0→1 reloads seed on the next edge, discarding the sequence position.
  - start 1→0 resumes advancing from the currently loaded value.
- Outputs are purely registered, with no combinational path from inputs to out or valid.

Test Plan:
- Reset: assert rst with start=0 -> out=16'h0001 and valid=0 immediately, without waiting for a clock edge. Deassert rst with start=0 -> first edge gives out=16'h0002, valid=1.
- Seed load and run: seed=16'h4242, start=1 for one edge -> out=16'h4242, valid=0. Then start=0 -> successive edges give 16'h8484, 16'h0908, 16'h1210, with valid=1.
- Zero seed: seed=0, start=1 -> out=16'h0001. start=0 -> next out=16'h0002.
- Period and nonzero check: load 16'h4242, run 65535 edges -> out==16'h4242 exactly at edge 65535, out never 0, and no earlier repeat of 16'h4242.
- Mid-run reload and reset:
  - Running from 16'h4242, set seed=16'hBEEF and start=1 -> next edge out=16'hBEEF, valid=0.
  - Assert rst between edges -> out=16'h0001 asynchronously.
- Fraction view: after loading 16'h4242, out[7:0]=8'h42 -> consumer fraction 66/256 = 0.257812.
